// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: phase-accumulator pixel strobe, sync/blank
// decode, line/frame strobes, and a position running LEAD pixels ahead for fetches.
module vga_timing_gen #(
  parameter int          HD     = 640,
  parameter int          HF     = 16,
  parameter int          HS     = 96,
  parameter int          HB     = 48,
  parameter int          VD     = 480,
  parameter int          VF     = 10,
  parameter int          VS     = 2,
  parameter int          VB     = 33,
  parameter logic        HS_POL = 1'b0,
  parameter logic        VS_POL = 1'b0,
  parameter logic [15:0] CE_INC = 16'h4000,
  parameter int          LEAD   = 2,
  parameter int          W      = 16
) (
  input  logic         clk,
  input  logic         rst,
  output logic         ce,
  output logic         hs,
  output logic         vs,
  output logic         en,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         line_start,
  output logic         frame_start,
  output logic         fetch_en,
  output logic [W-1:0] fetch_x,
  output logic [W-1:0] fetch_y
);

  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;

  localparam logic [W-1:0] ONE    = W'(1);
  localparam logic [W-1:0] H_LAST = W'(HT - 1);
  localparam logic [W-1:0] V_LAST = W'(VT - 1);
  localparam logic [W-1:0] H_ACT  = W'(HD);
  localparam logic [W-1:0] V_ACT  = W'(VD);
  localparam logic [W-1:0] H_SS   = W'(HD + HF);
  localparam logic [W-1:0] H_SE   = W'(HD + HF + HS);
  localparam logic [W-1:0] V_SS   = W'(VD + VF);
  localparam logic [W-1:0] V_SE   = W'(VD + VF + VS);
  // Fetch counters start LEAD raster steps after the (HT-1, VT-1) reset position.
  localparam logic [W-1:0] FH0    = (LEAD == 0) ? H_LAST : W'(LEAD - 1);
  localparam logic [W-1:0] FV0    = (LEAD == 0) ? V_LAST : '0;

  function automatic logic active(input logic [W-1:0] h, input logic [W-1:0] v);
    return (h < H_ACT) && (v < V_ACT);
  endfunction

  logic [15:0]  acc;
  logic [16:0]  sum;
  logic         tick;
  logic [W-1:0] hc, vc, fh, fv;
  logic [W-1:0] hc_n, vc_n, fh_n, fv_n;

  assign sum  = {1'b0, acc} + {1'b0, CE_INC};
  assign tick = sum[16];

  always_comb begin
    hc_n = hc;
    vc_n = vc;
    fh_n = fh;
    fv_n = fv;
    if (tick) begin
      if (hc == H_LAST) begin
        hc_n = '0;
        vc_n = (vc == V_LAST) ? '0 : vc + ONE;
      end else begin
        hc_n = hc + ONE;
      end
      if (fh == H_LAST) begin
        fh_n = '0;
        fv_n = (fv == V_LAST) ? '0 : fv + ONE;
      end else begin
        fh_n = fh + ONE;
      end
    end
  end

  // Outputs are decoded from the next counter values so they switch with the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      hc          <= H_LAST;
      vc          <= V_LAST;
      fh          <= FH0;
      fv          <= FV0;
      ce          <= 1'b0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      en          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      fetch_en    <= active(FH0, FV0);
      fetch_x     <= active(FH0, FV0) ? FH0 : '0;
      fetch_y     <= active(FH0, FV0) ? FV0 : '0;
    end else begin
      acc         <= sum[15:0];
      hc          <= hc_n;
      vc          <= vc_n;
      fh          <= fh_n;
      fv          <= fv_n;
      ce          <= tick;
      hs          <= (hc_n >= H_SS && hc_n < H_SE) ? HS_POL : ~HS_POL;
      vs          <= (vc_n >= V_SS && vc_n < V_SE) ? VS_POL : ~VS_POL;
      en          <= active(hc_n, vc_n);
      x           <= active(hc_n, vc_n) ? hc_n : '0;
      y           <= active(hc_n, vc_n) ? vc_n : '0;
      line_start  <= tick && (hc_n == '0);
      frame_start <= tick && (hc_n == '0) && (vc_n == '0);
      fetch_en    <= active(fh_n, fv_n);
      fetch_x     <= active(fh_n, fv_n) ? fh_n : '0;
      fetch_y     <= active(fh_n, fv_n) ? fv_n : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four configurations checked every clk against a
// linear raster-index model, plus targeted sync, strobe, reset and freeze checks.
module tb_vga_timing_gen;

  typedef struct packed {
    int hd, hf, hs, hb, vd, vf, vs, vb;
    logic hp;
    logic vp;
    int inc;
    int lead;
  } cfg_t;

  typedef struct packed {
    logic ce, hs, vs, en, ls, fs, fe;
    logic [15:0] x, y, fx, fy;
  } obs_t;

  localparam cfg_t CA = '{hd:640, hf:16, hs:96, hb:48, vd:480, vf:10, vs:2, vb:33,
                          hp:1'b0, vp:1'b0, inc:'h4000, lead:2};
  localparam cfg_t CB = '{hd:4, hf:1, hs:2, hb:1, vd:3, vf:1, vs:1, vb:1,
                          hp:1'b1, vp:1'b1, inc:'h8000, lead:3};
  localparam cfg_t CC = '{hd:4, hf:1, hs:2, hb:1, vd:3, vf:1, vs:1, vb:1,
                          hp:1'b0, vp:1'b0, inc:0, lead:0};
  localparam cfg_t CD = '{hd:10, hf:2, hs:3, hb:2, vd:5, vf:1, vs:2, vb:1,
                          hp:1'b0, vp:1'b0, inc:'h6A3D, lead:13};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1, rst_d = 1'b1;
  longint k_a = 0, k_b = 0, k_c = 0, k_d = 0;
  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  // Edge counts since the last clk with reset asserted; the model is a function of these.
  always @(posedge clk) begin
    k_a <= rst_a ? 64'd0 : k_a + 1;
    k_b <= rst_b ? 64'd0 : k_b + 1;
    k_c <= rst_c ? 64'd0 : k_c + 1;
    k_d <= rst_d ? 64'd0 : k_d + 1;
  end

  logic ce_a, hs_a, vs_a, en_a, ls_a, fs_a, fe_a;
  logic [15:0] x_a, y_a, fx_a, fy_a;
  logic ce_b, hs_b, vs_b, en_b, ls_b, fs_b, fe_b;
  logic [15:0] x_b, y_b, fx_b, fy_b;
  logic ce_c, hs_c, vs_c, en_c, ls_c, fs_c, fe_c;
  logic [15:0] x_c, y_c, fx_c, fy_c;
  logic ce_d, hs_d, vs_d, en_d, ls_d, fs_d, fe_d;
  logic [15:0] x_d, y_d, fx_d, fy_d;
  obs_t o_a, o_b, o_c, o_d;

  assign o_a = {ce_a, hs_a, vs_a, en_a, ls_a, fs_a, fe_a, x_a, y_a, fx_a, fy_a};
  assign o_b = {ce_b, hs_b, vs_b, en_b, ls_b, fs_b, fe_b, x_b, y_b, fx_b, fy_b};
  assign o_c = {ce_c, hs_c, vs_c, en_c, ls_c, fs_c, fe_c, x_c, y_c, fx_c, fy_c};
  assign o_d = {ce_d, hs_d, vs_d, en_d, ls_d, fs_d, fe_d, x_d, y_d, fx_d, fy_d};

  vga_timing_gen #(.HD(CA.hd), .HF(CA.hf), .HS(CA.hs), .HB(CA.hb), .VD(CA.vd), .VF(CA.vf),
    .VS(CA.vs), .VB(CA.vb), .HS_POL(CA.hp), .VS_POL(CA.vp), .CE_INC(CA.inc[15:0]),
    .LEAD(CA.lead), .W(16)) dut_a (
    .clk(clk), .rst(rst_a), .ce(ce_a), .hs(hs_a), .vs(vs_a), .en(en_a), .x(x_a), .y(y_a),
    .line_start(ls_a), .frame_start(fs_a), .fetch_en(fe_a), .fetch_x(fx_a), .fetch_y(fy_a));

  vga_timing_gen #(.HD(CB.hd), .HF(CB.hf), .HS(CB.hs), .HB(CB.hb), .VD(CB.vd), .VF(CB.vf),
    .VS(CB.vs), .VB(CB.vb), .HS_POL(CB.hp), .VS_POL(CB.vp), .CE_INC(CB.inc[15:0]),
    .LEAD(CB.lead), .W(16)) dut_b (
    .clk(clk), .rst(rst_b), .ce(ce_b), .hs(hs_b), .vs(vs_b), .en(en_b), .x(x_b), .y(y_b),
    .line_start(ls_b), .frame_start(fs_b), .fetch_en(fe_b), .fetch_x(fx_b), .fetch_y(fy_b));

  vga_timing_gen #(.HD(CC.hd), .HF(CC.hf), .HS(CC.hs), .HB(CC.hb), .VD(CC.vd), .VF(CC.vf),
    .VS(CC.vs), .VB(CC.vb), .HS_POL(CC.hp), .VS_POL(CC.vp), .CE_INC(CC.inc[15:0]),
    .LEAD(CC.lead), .W(16)) dut_c (
    .clk(clk), .rst(rst_c), .ce(ce_c), .hs(hs_c), .vs(vs_c), .en(en_c), .x(x_c), .y(y_c),
    .line_start(ls_c), .frame_start(fs_c), .fetch_en(fe_c), .fetch_x(fx_c), .fetch_y(fy_c));

  vga_timing_gen #(.HD(CD.hd), .HF(CD.hf), .HS(CD.hs), .HB(CD.hb), .VD(CD.vd), .VF(CD.vf),
    .VS(CD.vs), .VB(CD.vb), .HS_POL(CD.hp), .VS_POL(CD.vp), .CE_INC(CD.inc[15:0]),
    .LEAD(CD.lead), .W(16)) dut_d (
    .clk(clk), .rst(rst_d), .ce(ce_d), .hs(hs_d), .vs(vs_d), .en(en_d), .x(x_d), .y(y_d),
    .line_start(ls_d), .frame_start(fs_d), .fetch_en(fe_d), .fetch_x(fx_d), .fetch_y(fy_d));

  // After k clks the accumulator has produced n = floor(k*inc/2^16) strobes; the
  // position is raster index (n-1) mod frame size, starting from the last pixel.
  function automatic obs_t model(input cfg_t c, input longint k);
    longint ht, vt, t, n, n0, p, pf, h, v, fh, fv;
    obs_t o;
    ht = longint'(c.hd + c.hf + c.hs + c.hb);
    vt = longint'(c.vd + c.vf + c.vs + c.vb);
    t  = ht * vt;
    n  = (k * c.inc) >>> 16;
    n0 = (k > 0) ? (((k - 1) * c.inc) >>> 16) : 0;
    p  = (n + t - 1) % t;
    pf = (n + t - 1 + c.lead) % t;
    h  = p % ht;
    v  = p / ht;
    fh = pf % ht;
    fv = pf / ht;
    o.ce = (n != n0);
    o.hs = (h >= c.hd + c.hf && h < c.hd + c.hf + c.hs) ? c.hp : ~c.hp;
    o.vs = (v >= c.vd + c.vf && v < c.vd + c.vf + c.vs) ? c.vp : ~c.vp;
    o.en = (h < c.hd) && (v < c.vd);
    o.ls = o.ce && (h == 0);
    o.fs = o.ce && (p == 0);
    o.fe = (fh < c.hd) && (fv < c.vd);
    o.x  = o.en ? h[15:0] : 16'd0;
    o.y  = o.en ? v[15:0] : 16'd0;
    o.fx = o.fe ? fh[15:0] : 16'd0;
    o.fy = o.fe ? fv[15:0] : 16'd0;
    return o;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (o_a !== model(CA, 0)) begin bad++; $display("FAIL reset_a got=%h exp=%h", o_a, model(CA, 0)); end
    total++; if (o_b !== model(CB, 0)) begin bad++; $display("FAIL reset_b got=%h exp=%h", o_b, model(CB, 0)); end
    total++; if (o_c !== model(CC, 0)) begin bad++; $display("FAIL reset_c got=%h exp=%h", o_c, model(CC, 0)); end
    total++; if (o_d !== model(CD, 0)) begin bad++; $display("FAIL reset_d got=%h exp=%h", o_d, model(CD, 0)); end
    total++;
    if ({ce_a, en_a, hs_a, vs_a, ls_a, fs_a, fe_a, x_a, y_a, fx_a, fy_a} !==
        {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0, 16'd1, 16'd0}) begin
      bad++; $display("FAIL reset_values got=%h exp=fetch_en=1 fetch_x=1 rest idle", o_a);
    end
  endtask

  task automatic test_first_frame();
    obs_t e;
    bit seen;
    int w;
    seen = 0;
    rst_a = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      e = model(CA, k_a);
      total++; if (o_a !== e) begin bad++; $display("FAIL first_frame k=%0d got=%h exp=%h", k_a, o_a, e); end
      if (fs_a === 1'b1) seen = 1;
    end
    total++; if (!seen) begin bad++; $display("FAIL first_fs_timeout got=0 exp=1"); end
    total++; if (k_a != 4) begin bad++; $display("FAIL first_fs_latency got=%0d exp=4", k_a); end
    total++;
    if ({ls_a, en_a, x_a, y_a, fe_a, fx_a, fy_a} !== {1'b1, 1'b1, 16'd0, 16'd0, 1'b1, 16'd2, 16'd0}) begin
      bad++; $display("FAIL first_pixel got=%h exp=ls=1 en=1 (0,0) fetch=(2,0)", o_a);
    end
    for (int j = 0; j < 5; j++) begin
      w = 0;
      do begin @(negedge clk); w++; end while (ce_a !== 1'b1 && w < 8);
      total++; if (w != 4) begin bad++; $display("FAIL ce_period got=%0d exp=4", w); end
    end
  endtask

  task automatic test_hsync();
    obs_t e;
    longint fall_k, rise_k;
    logic prev;
    fall_k = -1;
    rise_k = -1;
    prev = hs_a;
    while (k_a < 6408) begin
      @(negedge clk);
      e = model(CA, k_a);
      total++; if (o_a !== e) begin bad++; $display("FAIL raster_a k=%0d got=%h exp=%h", k_a, o_a, e); end
      if (prev === 1'b1 && hs_a === 1'b0 && fall_k < 0) fall_k = k_a;
      if (prev === 1'b0 && hs_a === 1'b1 && fall_k >= 0 && rise_k < 0) rise_k = k_a;
      if (en_a === 1'b1 && x_a == 16'd638) begin
        total++;
        if (fe_a !== 1'b0 || fx_a !== 16'd0) begin
          bad++; $display("FAIL fetch_line_end got=fe%b fx%0d exp=fe0 fx0", fe_a, fx_a);
        end
      end
      prev = hs_a;
    end
    total++; if (fall_k != 2628) begin bad++; $display("FAIL hs_fall got=%0d exp=2628", fall_k); end
    total++; if (rise_k - fall_k != 384) begin bad++; $display("FAIL hs_width got=%0d exp=384", rise_k - fall_k); end
  endtask

  task automatic test_mid_reset();
    obs_t e;
    bit hit, seen;
    hit = 0;
    seen = 0;
    for (int i = 0; i < 4000 && !hit; i++) begin
      @(negedge clk);
      e = model(CA, k_a);
      total++; if (o_a !== e) begin bad++; $display("FAIL pre_reset k=%0d got=%h exp=%h", k_a, o_a, e); end
      if (en_a === 1'b1 && ce_a === 1'b1 && x_a == 16'd300) hit = 1;
    end
    total++; if (!hit) begin bad++; $display("FAIL reach_x300 got=0 exp=1"); end
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    total++; if (o_a !== model(CA, 0)) begin bad++; $display("FAIL mid_reset got=%h exp=%h", o_a, model(CA, 0)); end
    total++;
    if ({ce_a, en_a, hs_a, vs_a, x_a, y_a} !== {1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 16'd0}) begin
      bad++; $display("FAIL mid_reset_idle got=%h exp=idle", o_a);
    end
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      e = model(CA, k_a);
      total++; if (o_a !== e) begin bad++; $display("FAIL post_reset k=%0d got=%h exp=%h", k_a, o_a, e); end
      if (fs_a === 1'b1) seen = 1;
    end
    total++;
    if (!seen || k_a != 4 || x_a !== 16'd0 || y_a !== 16'd0 || ls_a !== 1'b1) begin
      bad++; $display("FAIL restart_frame got=seen%0d k%0d x%0d y%0d exp=seen1 k4 x0 y0", seen, k_a, x_a, y_a);
    end
  endtask

  task automatic test_small_frame();
    obs_t e;
    logic [31:0] ek;
    int hs_cnt, vs_cnt;
    hs_cnt = 0;
    vs_cnt = 0;
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    for (int f = 0; f < 3; f++) exp_q.push_back(32'(2 + f * 96));
    while (k_b < 200) begin
      @(negedge clk);
      e = model(CB, k_b);
      total++; if (o_b !== e) begin bad++; $display("FAIL small_raster k=%0d got=%h exp=%h", k_b, o_b, e); end
      if (fs_b === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL extra_frame_start got=k%0d exp=none", k_b);
        end else begin
          ek = exp_q.pop_front();
          if (k_b != longint'(ek)) begin bad++; $display("FAIL frame_start_k got=%0d exp=%0d", k_b, ek); end
        end
      end
      if (k_b >= 2 && k_b < 98) begin
        hs_cnt += int'(hs_b);
        vs_cnt += int'(vs_b);
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL missing_frame_start got=%0d left exp=0", exp_q.size()); end
    total++; if (hs_cnt != 24) begin bad++; $display("FAIL hs_high_clks got=%0d exp=24", hs_cnt); end
    total++; if (vs_cnt != 16) begin bad++; $display("FAIL vs_high_clks got=%0d exp=16", vs_cnt); end
  endtask

  task automatic test_freeze();
    obs_t e;
    rst_c = 1'b1;
    @(negedge clk);
    rst_c = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      e = model(CC, k_c);
      total++; if (o_c !== e) begin bad++; $display("FAIL freeze k=%0d got=%h exp=%h", k_c, o_c, e); end
    end
    total++;
    if ({ce_c, en_c, hs_c, vs_c, fe_c, fx_c} !== {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0}) begin
      bad++; $display("FAIL freeze_idle got=%h exp=idle with fetch_en=0", o_c);
    end
  endtask

  task automatic test_random();
    obs_t e;
    int run;
    for (int it = 0; it < 15; it++) begin
      rst_d = 1'b0;
      run = int'($urandom_range(40, 700));
      repeat (run) begin
        @(negedge clk);
        e = model(CD, k_d);
        total++; if (o_d !== e) begin bad++; $display("FAIL random_run k=%0d got=%h exp=%h", k_d, o_d, e); end
      end
      rst_d = 1'b1;
      repeat (int'($urandom_range(1, 3))) begin
        @(negedge clk);
        e = model(CD, k_d);
        total++; if (o_d !== e) begin bad++; $display("FAIL random_reset k=%0d got=%h exp=%h", k_d, o_d, e); end
      end
    end
    rst_d = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_hsync();
    test_mid_reset();
    test_small_frame();
    test_freeze();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
